// File: rtl/inst_fetch_if.sv
// inst_fetch_if -- signal bundle between the instruction fetch unit, the
// datapath and the instruction memory.
//   slave  : the fetch unit itself (consumes start/ack/pc_we/pc_next and the
//            memory response, drives the memory request and the IR/PC state)
//   master : the surrounding datapath + memory model that drives the fetch unit
interface inst_fetch_if;
    // datapath control
    logic        start;
    logic        ack;
    logic        pc_we;
    logic [63:0] pc_next;
    // instruction memory
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    // fetch results / status
    logic [31:0] ir_out;
    logic        ir_valid;
    logic [63:0] pc_out;
    logic [63:0] pc_inst;
    logic        busy;
    logic        fetch_err;

    modport slave (
        input  start, ack, pc_we, pc_next, mem_ready, mem_rdata,
        output mem_req, mem_addr, ir_out, ir_valid, pc_out, pc_inst, busy, fetch_err
    );

    modport master (
        output start, ack, pc_we, pc_next, mem_ready, mem_rdata,
        input  mem_req, mem_addr, ir_out, ir_valid, pc_out, pc_inst, busy, fetch_err
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch -- single-outstanding instruction fetch unit.
// Owns the PC and the instruction register. On start it issues one read at
// pc_out, waits up to TIMEOUT cycles for mem_ready, latches the word into
// ir_out (remembering its address in pc_inst), advances the PC by 4 and holds
// the instruction until the datapath acks it. Misaligned PCs and memory
// timeouts park the unit in an absorbing error state until reset.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - inst_fetch_if.slave: start/ack/pc_we/pc_next from the datapath,
//          mem_req/mem_addr/mem_ready/mem_rdata to instruction memory,
//          ir_out/ir_valid/pc_out/pc_inst/busy/fetch_err back to the datapath
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.slave  bus
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      NOP     = 32'h00000013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [63:0]      pc_q;
    logic [63:0]      pc_inst_q;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;

    // The PC a fetch launched this cycle would use: a same-cycle overwrite wins,
    // so the alignment check must look at it rather than the stale PC.
    logic [63:0] fetch_pc;
    logic        in_mem;
    logic        capture;

    assign fetch_pc = bus.pc_we ? bus.pc_next : pc_q;
    assign in_mem   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign capture  = in_mem && bus.mem_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (fetch_pc[1:0] != 2'b00) ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                state_d = bus.mem_ready ? S_HOLD : S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_ERR;
                end
            end
            S_HOLD: begin
                // start alone does nothing here: the held word is not yet consumed
                if (bus.ack) begin
                    if (bus.start) begin
                        state_d = (fetch_pc[1:0] != 2'b00) ? S_ERR : S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.mem_req   = in_mem;
        bus.busy      = in_mem;
        bus.ir_valid  = (state_q == S_HOLD);
        bus.fetch_err = (state_q == S_ERR);
    end

    assign bus.mem_addr = pc_q;
    assign bus.pc_out   = pc_q;
    assign bus.pc_inst  = pc_inst_q;
    assign bus.ir_out   = ir_q;

    // PC, IR and timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            pc_inst_q <= 64'h0;
            ir_q      <= NOP;
            cnt_q     <= '0;
        end else begin
            if (capture) begin
                ir_q      <= bus.mem_rdata;
                pc_inst_q <= pc_q;
                pc_q      <= pc_q + 64'd4;
            end else if (bus.pc_we && (state_q == S_IDLE || state_q == S_HOLD)) begin
                // overwrites are blocked mid-transaction so mem_addr stays put
                pc_q <= bus.pc_next;
            end

            if (state_q == S_REQ) begin
                cnt_q <= '0;
            end else if (state_q == S_WAIT && !bus.mem_ready && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch -- directed bench for inst_fetch. Two instances: one at the
// default RESET_PC for the main sequence, one at RESET_PC = 2^64-4 for the
// PC wrap case.
module tb_inst_fetch;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    inst_fetch_if ifa ();
    inst_fetch_if ifb ();

    inst_fetch #(.RESET_PC(64'h0), .TIMEOUT(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    inst_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .TIMEOUT(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic mem_req_seen;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        ifa.start = 0; ifa.ack = 0; ifa.pc_we = 0; ifa.pc_next = '0;
        ifa.mem_ready = 0; ifa.mem_rdata = '0;
        ifb.start = 0; ifb.ack = 0; ifb.pc_we = 0; ifb.pc_next = '0;
        ifb.mem_ready = 0; ifb.mem_rdata = '0;

        // ---- reset values ----
        #2 rst = 1'b1;
        #1;
        chk("rst_pc_out",   ifa.pc_out,            64'h0);
        chk("rst_pc_inst",  ifa.pc_inst,           64'h0);
        chk("rst_ir_out",   64'(ifa.ir_out),       64'h13);
        chk("rst_ir_valid", 64'(ifa.ir_valid),     64'h0);
        chk("rst_mem_req",  64'(ifa.mem_req),      64'h0);
        chk("rst_busy",     64'(ifa.busy),         64'h0);
        chk("rst_err",      64'(ifa.fetch_err),    64'h0);
        chk("rst_b_pc_out", ifb.pc_out,            64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_wait_busy", 64'(ifa.busy), 64'h0);

        // ---- minimum-latency fetch at PC 0 ----
        ifa.start = 1; ifa.mem_ready = 1; ifa.mem_rdata = 32'h00500093;
        tick();
        ifa.start = 0;
        chk("f0_req_mem_req",  64'(ifa.mem_req),  64'h1);
        chk("f0_req_addr",     ifa.mem_addr,      64'h0);
        chk("f0_req_ir_valid", 64'(ifa.ir_valid), 64'h0);
        tick();
        chk("f0_ir_valid", 64'(ifa.ir_valid), 64'h1);
        chk("f0_ir_out",   64'(ifa.ir_out),   64'h00500093);
        chk("f0_pc_inst",  ifa.pc_inst,       64'h0);
        chk("f0_pc_out",   ifa.pc_out,        64'h4);
        chk("f0_busy",     64'(ifa.busy),     64'h0);
        ifa.mem_ready = 0; ifa.mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("f0_hold_valid", 64'(ifa.ir_valid), 64'h1);
        chk("f0_hold_ir",    64'(ifa.ir_out),   64'h00500093);
        ifa.ack = 1;
        tick();
        ifa.ack = 0;
        chk("f0_ack_valid", 64'(ifa.ir_valid), 64'h0);

        // ---- fetch at PC 4 with mem_ready delayed 5 cycles; pc_we ignored ----
        ifa.start = 1;
        tick();
        ifa.start = 0;
        ifa.pc_we = 1; ifa.pc_next = 64'h100;
        for (int i = 0; i < 5; i++) begin
            chk("f4_wait_busy", 64'(ifa.busy), 64'h1);
            chk("f4_wait_addr", ifa.mem_addr,  64'h4);
            tick();
        end
        chk("f4_c6_busy", 64'(ifa.busy), 64'h1);
        chk("f4_c6_addr", ifa.mem_addr,  64'h4);
        ifa.pc_we = 0;
        ifa.mem_ready = 1; ifa.mem_rdata = 32'h00A00113;
        tick();
        chk("f4_ir_out",  64'(ifa.ir_out),    64'h00A00113);
        chk("f4_pc_inst", ifa.pc_inst,        64'h4);
        chk("f4_pc_out",  ifa.pc_out,         64'h8);
        chk("f4_err",     64'(ifa.fetch_err), 64'h0);
        chk("f4_valid",   64'(ifa.ir_valid),  64'h1);

        // ---- ack + start together: straight to REQ, fetch at PC 8 ----
        ifa.ack = 1; ifa.start = 1; ifa.mem_rdata = 32'h00000033;
        tick();
        ifa.ack = 0; ifa.start = 0;
        chk("f8_req_mem_req", 64'(ifa.mem_req),  64'h1);
        chk("f8_req_valid",   64'(ifa.ir_valid), 64'h0);
        chk("f8_req_addr",    ifa.mem_addr,      64'h8);
        tick();
        chk("f8_pc_inst", ifa.pc_inst,      64'h8);
        chk("f8_ir_out",  64'(ifa.ir_out),  64'h00000033);
        chk("f8_pc_out",  ifa.pc_out,       64'hC);

        // ---- pc_we in HOLD ----
        ifa.mem_ready = 0;
        ifa.pc_we = 1; ifa.pc_next = 64'h40;
        tick();
        ifa.pc_we = 0;
        chk("we_pc_out",  ifa.pc_out,       64'h40);
        chk("we_ir_out",  64'(ifa.ir_out),  64'h00000033);
        chk("we_pc_inst", ifa.pc_inst,      64'h8);
        chk("we_valid",   64'(ifa.ir_valid), 64'h1);
        ifa.ack = 1; ifa.start = 1; ifa.mem_ready = 1; ifa.mem_rdata = 32'h00108093;
        tick();
        ifa.ack = 0; ifa.start = 0;
        chk("f40_addr",    ifa.mem_addr,     64'h40);
        chk("f40_mem_req", 64'(ifa.mem_req), 64'h1);
        tick();
        ifa.mem_ready = 0;
        chk("f40_pc_inst", ifa.pc_inst, 64'h40);
        chk("f40_pc_out",  ifa.pc_out,  64'h44);

        // ---- misaligned PC -> absorbing error ----
        ifa.pc_we = 1; ifa.pc_next = 64'h42;
        tick();
        ifa.pc_we = 0;
        chk("mis_pc_out", ifa.pc_out, 64'h42);
        ifa.ack = 1;
        tick();
        ifa.ack = 0;
        ifa.start = 1;
        mem_req_seen = ifa.mem_req;
        tick();
        mem_req_seen = mem_req_seen | ifa.mem_req;
        chk("mis_err",   64'(ifa.fetch_err), 64'h1);
        chk("mis_valid", 64'(ifa.ir_valid),  64'h0);
        chk("mis_busy",  64'(ifa.busy),      64'h0);
        ifa.ack = 1; ifa.pc_we = 1; ifa.pc_next = 64'h80; ifa.mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_req_seen = mem_req_seen | ifa.mem_req;
        end
        ifa.start = 0; ifa.ack = 0; ifa.pc_we = 0; ifa.mem_ready = 0;
        chk("mis_no_mem_req", 64'(mem_req_seen),   64'h0);
        chk("mis_err_sticky", 64'(ifa.fetch_err),  64'h1);
        chk("mis_pc_frozen",  ifa.pc_out,          64'h42);
        rst = 1;
        #1;
        chk("mis_rst_err", 64'(ifa.fetch_err), 64'h0);
        chk("mis_rst_pc",  ifa.pc_out,         64'h0);
        @(negedge clk);
        rst = 0;
        tick();

        // ---- timeout with mem_ready held low ----
        ifa.start = 1;
        tick();
        ifa.start = 0;
        for (int i = 0; i < 16; i++) tick();
        chk("to_before_err",  64'(ifa.fetch_err), 64'h0);
        chk("to_before_busy", 64'(ifa.busy),      64'h1);
        tick();
        chk("to_err",     64'(ifa.fetch_err), 64'h1);
        chk("to_busy",    64'(ifa.busy),      64'h0);
        chk("to_mem_req", 64'(ifa.mem_req),   64'h0);
        chk("to_pc_out",  ifa.pc_out,         64'h0);
        chk("to_ir_out",  64'(ifa.ir_out),    64'h13);
        rst = 1;
        @(negedge clk);
        rst = 0;
        tick();

        // ---- pc_we in IDLE, then rst in the middle of WAIT ----
        ifa.pc_we = 1; ifa.pc_next = 64'h100;
        tick();
        ifa.pc_we = 0;
        chk("idle_we_pc", ifa.pc_out, 64'h100);
        ifa.start = 1;
        tick();
        ifa.start = 0;
        tick();
        tick();
        chk("mw_busy", 64'(ifa.busy), 64'h1);
        ifa.mem_ready = 1; ifa.mem_rdata = 32'hDEAD_BEEF;
        rst = 1;
        #1;
        chk("mw_rst_busy",    64'(ifa.busy),     64'h0);
        chk("mw_rst_mem_req", 64'(ifa.mem_req),  64'h0);
        chk("mw_rst_pc",      ifa.pc_out,        64'h0);
        chk("mw_rst_ir",      64'(ifa.ir_out),   64'h13);
        chk("mw_rst_valid",   64'(ifa.ir_valid), 64'h0);
        tick();
        chk("mw_no_capture",  64'(ifa.ir_out),   64'h13);
        chk("mw_no_pc_inst",  ifa.pc_inst,       64'h0);
        @(negedge clk);
        rst = 0;
        ifa.mem_ready = 0;
        tick();
        tick();
        chk("mw_idle_busy",  64'(ifa.busy),     64'h0);
        chk("mw_idle_valid", 64'(ifa.ir_valid), 64'h0);

        // ---- PC wrap on the second instance ----
        ifb.start = 1; ifb.mem_ready = 1; ifb.mem_rdata = 32'h00000013;
        tick();
        ifb.start = 0;
        chk("wrap_addr", ifb.mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_pc_out",  ifb.pc_out,        64'h0);
        chk("wrap_pc_inst", ifb.pc_inst,       64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_valid",   64'(ifb.ir_valid), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
